// File: rtl/clk_pkg.sv
// Shared definitions for the PLL reset controller: state encoding,
// default timing constants and the counter-width helper.
package clk_pkg;

  typedef enum logic [2:0] {
    ST_PRST      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_WAIT     = 50000;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_MAX_RETRY     = 4;

  localparam logic [7:0] RELOCK_SAT = 8'd255;

  // Width of the shared cycle counter: clog2 of the longest interval, at least 1 bit.
  function automatic int cnt_width(input int unsigned a, input int unsigned b,
                                   input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with a
// timeout and bounded retries, requires a stable lock window before
// releasing the system reset, and restarts on any lock loss.
module pll_reset_ctrl
  import clk_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_WAIT     = DEF_LOCK_WAIT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] relock_cnt
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_WAIT, STABLE_CYCLES);

  localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIM   = 4'(MAX_RETRY);

  logic          locked_s;
  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [3:0]    retry_r, retry_s, retry_inc_s;
  logic [7:0]    relock_r, relock_s;
  logic          pll_rst_r, sys_rst_r, ready_r, fail_r;
  logic          pll_rst_s, sys_rst_s, ready_s, fail_s;

  sync2 u_sync (
    .clk (clkin),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Next-state, counter, retry and relock bookkeeping.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    retry_s     = retry_r;
    relock_s    = relock_r;
    retry_inc_s = retry_r + 4'd1;
    case (state_r)
      ST_PRST: begin
        if (cnt_r == RST_LAST) begin
          state_s = ST_WAIT_LOCK;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout in the same cycle.
        if (locked_s) begin
          state_s = ST_STABLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == LOCK_LAST) begin
          retry_s = retry_inc_s;
          cnt_s   = CNT_ZERO;
          if (retry_inc_s == RETRY_LIM) begin
            state_s = ST_FAIL;
          end else begin
            state_s = ST_PRST;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_s = ST_PRST;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == STABLE_LAST) begin
          state_s = ST_RUN;
          cnt_s   = CNT_ZERO;
          retry_s = 4'd0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_s = ST_PRST;
          cnt_s   = CNT_ZERO;
          if (relock_r != RELOCK_SAT) begin
            relock_s = relock_r + 8'd1;
          end else begin
            relock_s = relock_r;
          end
        end else begin
          cnt_s = CNT_ZERO;
        end
      end
      ST_FAIL: begin
        cnt_s = CNT_ZERO;
      end
      default: begin
        state_s = ST_PRST;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Moore output decode from the next state so outputs register with it.
  always_comb begin
    pll_rst_s = 1'b1;
    sys_rst_s = 1'b1;
    ready_s   = 1'b0;
    fail_s    = 1'b0;
    case (state_s)
      ST_PRST:      pll_rst_s = 1'b1;
      ST_WAIT_LOCK: pll_rst_s = 1'b0;
      ST_STABLE:    pll_rst_s = 1'b0;
      ST_RUN: begin
        pll_rst_s = 1'b0;
        sys_rst_s = 1'b0;
        ready_s   = 1'b1;
      end
      ST_FAIL:      fail_s = 1'b1;
      default:      pll_rst_s = 1'b1;
    endcase
  end

  // State, counter and registered outputs with asynchronous reset.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_r   <= ST_PRST;
      cnt_r     <= CNT_ZERO;
      retry_r   <= 4'd0;
      relock_r  <= 8'd0;
      pll_rst_r <= 1'b1;
      sys_rst_r <= 1'b1;
      ready_r   <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      retry_r   <= retry_s;
      relock_r  <= relock_s;
      pll_rst_r <= pll_rst_s;
      sys_rst_r <= sys_rst_s;
      ready_r   <= ready_s;
      fail_r    <= fail_s;
    end
  end

  assign pll_rst    = pll_rst_r;
  assign sys_rst    = sys_rst_r;
  assign ready      = ready_r;
  assign fail       = fail_r;
  assign relock_cnt = relock_r;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed self-checking bench for pll_reset_ctrl with short timing
// parameters (RST 4, LOCK_WAIT 20, STABLE 8, MAX_RETRY 2). Cycle k is
// the interval after the k-th rising edge following reset release.
module tb_pll_reset_ctrl;

  logic       clkin;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [7:0] relock_cnt;

  int vectors;
  int miscompares;
  int cyc;
  int base;

  pll_reset_ctrl #(
    .RST_CYCLES    (4),
    .LOCK_WAIT     (20),
    .STABLE_CYCLES (8),
    .MAX_RETRY     (2)
  ) dut (
    .clkin      (clkin),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fail       (fail),
    .relock_cnt (relock_cnt)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Advance to cycle k, sampling 1 time unit after each rising edge.
  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clkin);
      #1;
      cyc++;
    end
  endtask

  task automatic release_rst();
    @(negedge clkin);
    rst = 1'b0;
    cyc = 0;
  endtask

  // Assert rst between clock edges and check the outputs respond at once.
  task automatic async_reset_check(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, "_pll_rst"}, pll_rst, 8'd1);
    chk({tag, "_sys_rst"}, sys_rst, 8'd1);
    chk({tag, "_ready"}, ready, 8'd0);
    chk({tag, "_fail"}, fail, 8'd0);
    chk({tag, "_relock"}, relock_cnt, 8'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst         = 1'b1;
    pll_locked  = 1'b0;
    repeat (3) @(posedge clkin);
    #1;
    chk("rst_pll_rst", pll_rst, 8'd1);
    chk("rst_sys_rst", sys_rst, 8'd1);
    chk("rst_ready", ready, 8'd0);
    chk("rst_fail", fail, 8'd0);
    chk("rst_relock", relock_cnt, 8'd0);

    // Normal lock: pll_locked rises at cycle 10, RUN at cycle 21.
    release_rst();
    chk("lock_prst_c0", pll_rst, 8'd1);
    goto(3);  chk("lock_prst_c3", pll_rst, 8'd1);
    goto(4);  chk("lock_wait_c4", pll_rst, 8'd0);
              chk("lock_wait_sys", sys_rst, 8'd1);
    goto(10); pll_locked = 1'b1;
    goto(20); chk("lock_c20_ready", ready, 8'd0);
              chk("lock_c20_sys", sys_rst, 8'd1);
    goto(21); chk("lock_c21_ready", ready, 8'd1);
              chk("lock_c21_sys", sys_rst, 8'd0);
              chk("lock_c21_pll", pll_rst, 8'd0);

    // One-cycle lock loss in RUN at cycle 30.
    goto(30); pll_locked = 1'b0;
    goto(31); pll_locked = 1'b1;
    goto(32); chk("loss_c32_sys", sys_rst, 8'd0);
    goto(33); chk("loss_c33_sys", sys_rst, 8'd1);
              chk("loss_c33_ready", ready, 8'd0);
              chk("loss_c33_relock", relock_cnt, 8'd1);
              chk("loss_c33_pll", pll_rst, 8'd1);
    goto(36); chk("loss_c36_pll", pll_rst, 8'd1);
    goto(37); chk("loss_c37_pll", pll_rst, 8'd0);
    goto(45); chk("loss_c45_ready", ready, 8'd0);
    goto(46); chk("loss_c46_ready", ready, 8'd1);
              chk("loss_c46_relock", relock_cnt, 8'd1);

    // Drive the relock counter to saturation, then one more loss.
    for (int i = 0; i < 254; i++) begin
      base = cyc;
      pll_locked = 1'b0;
      goto(base + 1);
      pll_locked = 1'b1;
      goto(base + 16);
    end
    chk("sat_relock_255", relock_cnt, 8'd255);
    chk("sat_ready", ready, 8'd1);
    base = cyc;
    pll_locked = 1'b0;
    goto(base + 1);
    pll_locked = 1'b1;
    goto(base + 16);
    chk("sat_no_wrap", relock_cnt, 8'd255);
    chk("sat_ready2", ready, 8'd1);
    async_reset_check("arst_run");

    // Never locked: two timeouts then FAIL at cycle 48.
    pll_locked = 1'b0;
    release_rst();
    goto(23); chk("to_c23_pll", pll_rst, 8'd0);
    goto(24); chk("to_c24_pll", pll_rst, 8'd1);
              chk("to_c24_fail", fail, 8'd0);
    goto(27); chk("to_c27_pll", pll_rst, 8'd1);
    goto(28); chk("to_c28_pll", pll_rst, 8'd0);
    goto(47); chk("to_c47_fail", fail, 8'd0);
              chk("to_c47_sys", sys_rst, 8'd1);
    goto(48); chk("to_c48_fail", fail, 8'd1);
              chk("to_c48_pll", pll_rst, 8'd1);
              chk("to_c48_sys", sys_rst, 8'd1);
              chk("to_c48_ready", ready, 8'd0);
    pll_locked = 1'b1;
    goto(70); chk("fail_terminal", fail, 8'd1);
              chk("fail_term_ready", ready, 8'd0);
    async_reset_check("arst_fail");

    // Glitch in STABLE at cnt 5: locked_s low in cycle 10 only.
    release_rst();
    goto(8);  pll_locked = 1'b0;
    goto(9);  pll_locked = 1'b1;
    goto(10); chk("gl_c10_ready", ready, 8'd0);
              chk("gl_c10_pll", pll_rst, 8'd0);
    goto(11); chk("gl_c11_pll", pll_rst, 8'd1);
              chk("gl_c11_sys", sys_rst, 8'd1);
    goto(14); chk("gl_c14_pll", pll_rst, 8'd1);
    goto(15); chk("gl_c15_pll", pll_rst, 8'd0);
    goto(23); chk("gl_c23_ready", ready, 8'd0);
    goto(24); chk("gl_c24_ready", ready, 8'd1);
              chk("gl_c24_sys", sys_rst, 8'd0);

    // Retry count survives a STABLE glitch: one timeout, glitch, one more -> FAIL.
    rst = 1'b1;
    pll_locked = 1'b0;
    release_rst();
    goto(24); chk("rt_c24_pll", pll_rst, 8'd1);
    goto(28); pll_locked = 1'b1;
    goto(34); pll_locked = 1'b0;
    goto(36); chk("rt_c36_pll", pll_rst, 8'd0);
              chk("rt_c36_ready", ready, 8'd0);
    goto(37); chk("rt_c37_pll", pll_rst, 8'd1);
    goto(41); chk("rt_c41_pll", pll_rst, 8'd0);
    goto(60); chk("rt_c60_fail", fail, 8'd0);
    goto(61); chk("rt_c61_fail", fail, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
